relay_frame_assembler: RTL and testbench

Consumes the per-bit symbols from the relay bit decoder (4-bit symbol plus one-cycle `bit_valid` strobe, one symbol per 64 clk) and assembles them into bytes. Framing is: start bit, 8 data bits LSB first, optional parity bit, stop bit. Completed bytes go into a small first-word-fall-through (FWFT) FIFO with a valid/ready handshake toward the host-side reader. Framing, symbol, timeout and overflow errors are reported as single-cycle pulses.

---
 rtl/relay_frame_assembler.sv | 167 ++++++++++++++++
 tb/tb_relay_frame_assembler.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/relay_frame_assembler.sv
// Assembles relay bit-decoder symbols (start, 8 data LSB first, [parity], stop) into bytes
// and queues them in a FWFT FIFO. Optional parity bit enabled by defining RELAY_PARITY_EN.
module relay_frame_assembler #(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          mode,
  input  logic [3:0]                    bit_in,
  input  logic                          bit_valid,
  output logic [7:0]                    out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          busy,
  output logic                          frame_err,
  output logic                          symbol_err,
  output logic                          overflow,
  output logic                          parity_err
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

`ifdef RELAY_PARITY_EN
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, DATA, STOP} state_t;
`endif

  state_t          state;
  logic [2:0]      bit_cnt;
  logic [7:0]      shreg;
  logic            par_bad;
  logic [TW-1:0]   idle_cnt;
  logic [7:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [LW-1:0]   level;

  logic [3:0] one_sym;
  logic       is_one;
  logic       is_zero;
  logic       is_ill;
  logic       push_req;
  logic       push_ok;
  logic       pop;
  logic       full;

  always_comb begin
    one_sym  = mode ? 4'hC : 4'hF;
    is_one   = bit_valid && (bit_in == one_sym);
    is_zero  = bit_valid && (bit_in == 4'h0);
    is_ill   = bit_valid && !is_one && !is_zero;
    pop      = out_valid && out_ready;
    full     = (level == LW'(FIFO_DEPTH));
    push_req = (state == STOP) && is_zero && !par_bad;
    push_ok  = push_req && (!full || pop);
  end

  assign out_valid  = (level != '0);
  assign out_data   = out_valid ? mem[rd_ptr] : 8'h00;
  assign fifo_level = level;
  assign busy       = (state != IDLE);

  // Frame FSM; error outputs are registered single-cycle pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      shreg      <= '0;
      par_bad    <= 1'b0;
      idle_cnt   <= '0;
      frame_err  <= 1'b0;
      symbol_err <= 1'b0;
`ifdef RELAY_PARITY_EN
      parity_err <= 1'b0;
`endif
    end else begin
      frame_err  <= 1'b0;
      symbol_err <= 1'b0;
`ifdef RELAY_PARITY_EN
      parity_err <= 1'b0;
`endif
      if (state == IDLE || bit_valid) idle_cnt <= '0;
      else                            idle_cnt <= idle_cnt + TW'(1);

      if (state != IDLE && !bit_valid && idle_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
        state     <= IDLE;
        frame_err <= 1'b1;
      end else if (bit_valid) begin
        case (state)
          IDLE: begin
            if (is_one) begin
              state   <= DATA;
              bit_cnt <= '0;
              shreg   <= '0;
              par_bad <= 1'b0;
            end else if (is_ill) begin
              symbol_err <= 1'b1;
            end
          end
          DATA: begin
            if (is_ill) begin
              symbol_err <= 1'b1;
              state      <= IDLE;
            end else begin
              shreg[bit_cnt] <= is_one;
              bit_cnt        <= bit_cnt + 3'd1;
`ifdef RELAY_PARITY_EN
              if (bit_cnt == 3'd7) state <= PARITY;
`else
              if (bit_cnt == 3'd7) state <= STOP;
`endif
            end
          end
`ifdef RELAY_PARITY_EN
          PARITY: begin
            if (is_ill) begin
              symbol_err <= 1'b1;
              state      <= IDLE;
            end else begin
              if (is_one != ^shreg) begin
                parity_err <= 1'b1;
                par_bad    <= 1'b1;
              end
              state <= STOP;
            end
          end
`endif
          STOP: begin
            state <= IDLE;
            // After a parity failure the stop bit is consumed silently.
            if (!par_bad) begin
              if (is_ill)      symbol_err <= 1'b1;
              else if (is_one) frame_err  <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

`ifndef RELAY_PARITY_EN
  assign parity_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      overflow <= push_req && !push_ok;
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      level <= level + LW'(push_ok) - LW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && push_ok) mem[wr_ptr] <= shreg;
  end
endmodule

// File: tb/tb_relay_frame_assembler.sv
// Self-checking bench for relay_frame_assembler: directed scenarios plus randomized frames
// checked against a frame-level expectation model and a byte scoreboard.
module tb_relay_frame_assembler;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       mode = 1'b0;
  logic [3:0] bit_in = 4'h0;
  logic       bit_valid = 1'b0;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [2:0] fifo_level;
  logic       busy, frame_err, symbol_err, overflow, parity_err;

  int pass_cnt = 0;
  int total = 0;
  int n_fe = 0, n_se = 0, n_ov = 0, n_pe = 0, n_wide = 0;
  logic fe_d = 0, se_d = 0, ov_d = 0, pe_d = 0;
  logic [7:0] exp_q[$];
  logic [3:0] fr [0:10];
  int fr_n;

  always #5 clk = ~clk;

  relay_frame_assembler dut (
    .clk(clk), .reset(reset), .mode(mode), .bit_in(bit_in), .bit_valid(bit_valid),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .fifo_level(fifo_level), .busy(busy), .frame_err(frame_err),
    .symbol_err(symbol_err), .overflow(overflow), .parity_err(parity_err)
  );

  // Pulse counters and pulse-width watch
  always @(negedge clk) begin
    if (frame_err)  n_fe++;
    if (symbol_err) n_se++;
    if (overflow)   n_ov++;
    if (parity_err) n_pe++;
    if ((frame_err && fe_d) || (symbol_err && se_d) || (overflow && ov_d) || (parity_err && pe_d))
      n_wide++;
    fe_d = frame_err; se_d = symbol_err; ov_d = overflow; pe_d = parity_err;
  end

  function automatic logic [3:0] one_of(input logic m);
    return m ? 4'hC : 4'hF;
  endfunction

  // Builds a well-formed frame in fr[] for the current mode
  task automatic build_frame(input logic [7:0] b, input logic stop_one);
    logic [3:0] one;
    one = one_of(mode);
    fr[0] = one;
    for (int i = 0; i < 8; i++) fr[i+1] = b[i] ? one : 4'h0;
    fr_n = 10;
`ifdef RELAY_PARITY_EN
    fr[9] = (^b) ? one : 4'h0;
    fr_n = 11;
`endif
    fr[fr_n-1] = stop_one ? one : 4'h0;
  endtask

  task automatic send_sym(input logic [3:0] s, input int gap);
    bit_in = s;
    bit_valid = 1'b1;
    @(negedge clk);
    bit_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic send_syms(input int cnt, input int gap);
    for (int i = 0; i < cnt; i++) send_sym(fr[i], (i == cnt - 1) ? 0 : gap);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    total++; if (out_valid !== 1'b0)    $display("FAIL reset_out_valid got %b exp 0", out_valid); else pass_cnt++;
    total++; if (out_data !== 8'h00)    $display("FAIL reset_out_data got %h exp 00", out_data); else pass_cnt++;
    total++; if (fifo_level !== 3'd0)   $display("FAIL reset_level got %0d exp 0", fifo_level); else pass_cnt++;
    total++; if (busy !== 1'b0)         $display("FAIL reset_busy got %b exp 0", busy); else pass_cnt++;
    total++; if ({frame_err, symbol_err, overflow, parity_err} !== 4'b0)
      $display("FAIL reset_errs got %b exp 0000", {frame_err, symbol_err, overflow, parity_err}); else pass_cnt++;
  endtask

  task automatic test_basic_a5;
    int fe0, se0, ov0, pe0;
    fe0 = n_fe; se0 = n_se; ov0 = n_ov; pe0 = n_pe;
    mode = 1'b0;
    build_frame(8'hA5, 1'b0);
    send_syms(fr_n, 63);
    total++; if (out_valid !== 1'b1)  $display("FAIL a5_latency_valid got %b exp 1", out_valid); else pass_cnt++;
    total++; if (out_data !== 8'hA5)  $display("FAIL a5_data got %h exp a5", out_data); else pass_cnt++;
    total++; if (fifo_level !== 3'd1) $display("FAIL a5_level got %0d exp 1", fifo_level); else pass_cnt++;
    repeat (2) @(negedge clk);
    total++; if ((n_fe - fe0) + (n_se - se0) + (n_ov - ov0) + (n_pe - pe0) != 0)
      $display("FAIL a5_no_errs got %0d pulses exp 0", (n_fe - fe0) + (n_se - se0) + (n_ov - ov0) + (n_pe - pe0)); else pass_cnt++;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    total++; if (out_valid !== 1'b0)  $display("FAIL a5_drain got %b exp 0", out_valid); else pass_cnt++;
  endtask

  task automatic test_bad_stop;
    int fe0;
    fe0 = n_fe;
    mode = 1'b1;
    build_frame(8'h3C, 1'b1);
    send_syms(fr_n, 20);
    total++; if (frame_err !== 1'b1)  $display("FAIL badstop_pulse got %b exp 1", frame_err); else pass_cnt++;
    repeat (3) @(negedge clk);
    total++; if (n_fe - fe0 != 1)     $display("FAIL badstop_count got %0d exp 1", n_fe - fe0); else pass_cnt++;
    total++; if (fifo_level !== 3'd0) $display("FAIL badstop_level got %0d exp 0", fifo_level); else pass_cnt++;
    total++; if (busy !== 1'b0)       $display("FAIL badstop_busy got %b exp 0", busy); else pass_cnt++;
  endtask

  task automatic test_overflow;
    int ov0;
    mode = 1'b0;
    out_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      build_frame(8'(i), 1'b0);
      send_syms(fr_n, 4);
      exp_q.push_back(8'(i));
      @(negedge clk);
    end
    total++; if (fifo_level !== 3'd4) $display("FAIL ovf_level_full got %0d exp 4", fifo_level); else pass_cnt++;
    ov0 = n_ov;
    build_frame(8'h05, 1'b0);
    send_syms(fr_n, 4);
    total++; if (overflow !== 1'b1)   $display("FAIL ovf_pulse got %b exp 1", overflow); else pass_cnt++;
    repeat (2) @(negedge clk);
    total++; if (n_ov - ov0 != 1)     $display("FAIL ovf_count got %0d exp 1", n_ov - ov0); else pass_cnt++;
    total++; if (fifo_level !== 3'd4) $display("FAIL ovf_level_after got %0d exp 4", fifo_level); else pass_cnt++;
    out_ready = 1'b1;
    while (exp_q.size() > 0) begin
      logic [7:0] e;
      e = exp_q.pop_front();
      total++; if (out_valid !== 1'b1 || out_data !== e)
        $display("FAIL ovf_read got v=%b d=%h exp v=1 d=%h", out_valid, out_data, e); else pass_cnt++;
      @(negedge clk);
    end
    out_ready = 1'b0;
    total++; if (out_valid !== 1'b0)  $display("FAIL ovf_empty got %b exp 0", out_valid); else pass_cnt++;
  endtask

  task automatic test_timeout;
    int cyc;
    mode = 1'b0;
    build_frame(8'h00, 1'b0);
    send_syms(4, 63);
    total++; if (busy !== 1'b1) $display("FAIL to_busy got %b exp 1", busy); else pass_cnt++;
    cyc = 0;
    while (frame_err !== 1'b1 && cyc < 400) begin
      @(negedge clk);
      cyc++;
    end
    total++; if (cyc != 256)    $display("FAIL to_delay got %0d exp 256", cyc); else pass_cnt++;
    @(negedge clk);
    total++; if (busy !== 1'b0) $display("FAIL to_busy_fall got %b exp 0", busy); else pass_cnt++;
    build_frame(8'h5A, 1'b0);
    send_syms(fr_n, 63);
    total++; if (out_valid !== 1'b1 || out_data !== 8'h5A)
      $display("FAIL to_next_frame got v=%b d=%h exp v=1 d=5a", out_valid, out_data); else pass_cnt++;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_symbol_err;
    mode = 1'b1;
    send_sym(4'hC, 10);
    send_sym(4'h0, 10);
    send_sym(4'hF, 0);
    total++; if (symbol_err !== 1'b1 || busy !== 1'b0)
      $display("FAIL symerr_data got se=%b busy=%b exp se=1 busy=0", symbol_err, busy); else pass_cnt++;
    @(negedge clk);
    total++; if (symbol_err !== 1'b0) $display("FAIL symerr_width got %b exp 0", symbol_err); else pass_cnt++;
    send_sym(4'h7, 0);
    total++; if (symbol_err !== 1'b1 || busy !== 1'b0)
      $display("FAIL symerr_idle got se=%b busy=%b exp se=1 busy=0", symbol_err, busy); else pass_cnt++;
    @(negedge clk);
  endtask

  task automatic test_reset_midframe;
    int e0;
    mode = 1'b0;
    build_frame(8'h11, 1'b0);
    send_syms(fr_n, 3);
    build_frame(8'hFF, 1'b0);
    send_syms(4, 3);
    e0 = n_fe + n_se + n_ov + n_pe;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    total++; if (fifo_level !== 3'd0 || out_valid !== 1'b0 || out_data !== 8'h00 || busy !== 1'b0)
      $display("FAIL midreset got lvl=%0d v=%b d=%h busy=%b exp 0", fifo_level, out_valid, out_data, busy); else pass_cnt++;
    repeat (300) @(negedge clk);
    total++; if (n_fe + n_se + n_ov + n_pe != e0)
      $display("FAIL midreset_errs got %0d pulses exp 0", n_fe + n_se + n_ov + n_pe - e0); else pass_cnt++;
  endtask

`ifdef RELAY_PARITY_EN
  task automatic test_parity;
    int fe0, pe0;
    mode = 1'b0;
    build_frame(8'h07, 1'b0);
    send_syms(fr_n, 8);
    total++; if (out_valid !== 1'b1 || out_data !== 8'h07)
      $display("FAIL par_good got v=%b d=%h exp v=1 d=07", out_valid, out_data); else pass_cnt++;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    fe0 = n_fe; pe0 = n_pe;
    build_frame(8'h07, 1'b0);
    fr[9] = 4'h0;
    send_syms(fr_n, 8);
    repeat (2) @(negedge clk);
    total++; if (n_pe - pe0 != 1)     $display("FAIL par_bad_pulse got %0d exp 1", n_pe - pe0); else pass_cnt++;
    total++; if (n_fe - fe0 != 0)     $display("FAIL par_bad_fe got %0d exp 0", n_fe - fe0); else pass_cnt++;
    total++; if (fifo_level !== 3'd0) $display("FAIL par_bad_push got %0d exp 0", fifo_level); else pass_cnt++;
  endtask
`endif

  // Random frames: good, bad stop, or an illegal symbol at a random position
  task automatic test_random;
    for (int k = 0; k < 30; k++) begin
      int kind, gap, cut, pos, fe0, se0, pe0;
      logic [7:0] b;
      logic [3:0] v;
      mode = 1'($urandom_range(0, 1));
      b    = 8'($urandom_range(0, 255));
      kind = $urandom_range(0, 2);
      gap  = $urandom_range(1, 12);
      build_frame(b, kind == 1);
      cut = fr_n;
      if (kind == 2) begin
        pos = $urandom_range(1, fr_n - 1);
        do v = 4'($urandom_range(1, 15)); while (v == one_of(mode));
        fr[pos] = v;
        cut = pos + 1;
      end
      if (kind == 0) exp_q.push_back(b);
      fe0 = n_fe; se0 = n_se; pe0 = n_pe;
      send_syms(cut, gap);
      repeat (2) @(negedge clk);
      total++; if (n_fe - fe0 != ((kind == 1) ? 1 : 0) || n_se - se0 != ((kind == 2) ? 1 : 0) || n_pe != pe0)
        $display("FAIL rnd_errs k=%0d kind=%0d got fe=%0d se=%0d pe=%0d", k, kind, n_fe - fe0, n_se - se0, n_pe - pe0); else pass_cnt++;
      total++; if (busy !== 1'b0) $display("FAIL rnd_busy k=%0d got %b exp 0", k, busy); else pass_cnt++;
      if (kind == 0) begin
        logic [7:0] e;
        e = exp_q.pop_front();
        total++; if (out_valid !== 1'b1 || out_data !== e)
          $display("FAIL rnd_data k=%0d got v=%b d=%h exp d=%h", k, out_valid, out_data, e); else pass_cnt++;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
      end
      total++; if (fifo_level !== 3'd0) $display("FAIL rnd_level k=%0d got %0d exp 0", k, fifo_level); else pass_cnt++;
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset;
    test_basic_a5;
    test_bad_stop;
    test_overflow;
    test_timeout;
    test_symbol_err;
    test_reset_midframe;
`ifdef RELAY_PARITY_EN
    test_parity;
`endif
    test_random;
    total++; if (n_wide != 0) $display("FAIL pulse_width got %0d wide pulses exp 0", n_wide); else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
